// File: rtl/axi4l_arb2.sv
// Two-master round-robin AXI4-Lite arbiter serialising accesses to one register-bank slave.
// Define AXI4L_ARB2_TIMEOUT_EN to add the response watchdog and the DRAIN state.
module axi4l_arb2 #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset,
    // master 0
    input  logic                  m0_awvalid,
    input  logic [ADDR_WIDTH-1:2] m0_awaddr,
    input  logic [2:0]            m0_awprot,
    output logic                  m0_awready,
    input  logic                  m0_wvalid,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic                  m0_wready,
    output logic                  m0_bvalid,
    output logic [1:0]            m0_bresp,
    input  logic                  m0_bready,
    input  logic                  m0_arvalid,
    input  logic [ADDR_WIDTH-1:2] m0_araddr,
    input  logic [2:0]            m0_arprot,
    output logic                  m0_arready,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    output logic [1:0]            m0_rresp,
    input  logic                  m0_rready,
    // master 1
    input  logic                  m1_awvalid,
    input  logic [ADDR_WIDTH-1:2] m1_awaddr,
    input  logic [2:0]            m1_awprot,
    output logic                  m1_awready,
    input  logic                  m1_wvalid,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_wready,
    output logic                  m1_bvalid,
    output logic [1:0]            m1_bresp,
    input  logic                  m1_bready,
    input  logic                  m1_arvalid,
    input  logic [ADDR_WIDTH-1:2] m1_araddr,
    input  logic [2:0]            m1_arprot,
    output logic                  m1_arready,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic [1:0]            m1_rresp,
    input  logic                  m1_rready,
    // slave
    output logic                  s_awvalid,
    output logic [ADDR_WIDTH-1:2] s_awaddr,
    output logic [2:0]            s_awprot,
    input  logic                  s_awready,
    output logic                  s_wvalid,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    input  logic                  s_wready,
    input  logic                  s_bvalid,
    input  logic [1:0]            s_bresp,
    output logic                  s_bready,
    output logic                  s_arvalid,
    output logic [ADDR_WIDTH-1:2] s_araddr,
    output logic [2:0]            s_arprot,
    input  logic                  s_arready,
    input  logic                  s_rvalid,
    input  logic [31:0]           s_rdata,
    input  logic [1:0]            s_rresp,
    output logic                  s_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StGrantWr,
        StWaitB,
        StGrantRd,
        StWaitR
`ifdef AXI4L_ARB2_TIMEOUT_EN
        , StDrain
`endif
    } state_t;

    state_t state_q;
    logic   gnt_q, last_q, aw_done_q, w_done_q;
    logic   timed_out;

    logic                  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [ADDR_WIDTH-1:2] m_awaddr, m_araddr;
    logic [2:0]            m_awprot, m_arprot;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wstrb;

    logic        aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;

    logic wr0, wr1, req0, req1, pick, pick_wr;

    assign wr0  = m0_awvalid | m0_wvalid;
    assign wr1  = m1_awvalid | m1_wvalid;
    assign req0 = wr0 | m0_arvalid;
    assign req1 = wr1 | m1_arvalid;
    // The master that did not win last time gets first claim.
    assign pick    = last_q ? ~req0 : req1;
    assign pick_wr = pick ? wr1 : wr0;

    always_comb begin
        m_awvalid = gnt_q ? m1_awvalid : m0_awvalid;
        m_awaddr  = gnt_q ? m1_awaddr  : m0_awaddr;
        m_awprot  = gnt_q ? m1_awprot  : m0_awprot;
        m_wvalid  = gnt_q ? m1_wvalid  : m0_wvalid;
        m_wdata   = gnt_q ? m1_wdata   : m0_wdata;
        m_wstrb   = gnt_q ? m1_wstrb   : m0_wstrb;
        m_bready  = gnt_q ? m1_bready  : m0_bready;
        m_arvalid = gnt_q ? m1_arvalid : m0_arvalid;
        m_araddr  = gnt_q ? m1_araddr  : m0_araddr;
        m_arprot  = gnt_q ? m1_arprot  : m0_arprot;
        m_rready  = gnt_q ? m1_rready  : m0_rready;
    end

`ifdef AXI4L_ARB2_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          op_wr_q;
    assign timed_out = (cnt_q == CW'(TIMEOUT));
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
    assign timed_out  = 1'b0;
`endif

    always_comb begin
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awprot  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_rready  = 1'b0;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        ar_rdy    = 1'b0;
        b_vld     = 1'b0;
        b_resp    = '0;
        r_vld     = 1'b0;
        r_resp    = '0;
        r_data    = '0;
        unique case (state_q)
            StGrantWr: begin
                s_awvalid = m_awvalid & ~aw_done_q;
                s_awaddr  = m_awaddr;
                s_awprot  = m_awprot;
                s_wvalid  = m_wvalid & ~w_done_q;
                s_wdata   = m_wdata;
                s_wstrb   = m_wstrb;
                aw_rdy    = s_awready & ~aw_done_q;
                w_rdy     = s_wready & ~w_done_q;
            end
            StWaitB: begin
                if (timed_out) begin
                    b_vld  = 1'b1;
                    b_resp = 2'b10;
                end else begin
                    s_bready = m_bready;
                    b_vld    = s_bvalid;
                    b_resp   = s_bresp;
                end
            end
            StGrantRd: begin
                s_arvalid = m_arvalid;
                s_araddr  = m_araddr;
                s_arprot  = m_arprot;
                ar_rdy    = s_arready;
            end
            StWaitR: begin
                if (timed_out) begin
                    r_vld  = 1'b1;
                    r_resp = 2'b10;
                end else begin
                    s_rready = m_rready;
                    r_vld    = s_rvalid;
                    r_data   = s_rdata;
                    r_resp   = s_rresp;
                end
            end
`ifdef AXI4L_ARB2_TIMEOUT_EN
            StDrain: begin
                s_bready = op_wr_q;
                s_rready = ~op_wr_q;
            end
`endif
            default: ;
        endcase
    end

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign ar_hs = s_arvalid & s_arready;
    assign b_hs  = b_vld & m_bready;
    assign r_hs  = r_vld & m_rready;

    assign m0_awready = aw_rdy & ~gnt_q;
    assign m1_awready = aw_rdy & gnt_q;
    assign m0_wready  = w_rdy & ~gnt_q;
    assign m1_wready  = w_rdy & gnt_q;
    assign m0_bvalid  = b_vld & ~gnt_q;
    assign m1_bvalid  = b_vld & gnt_q;
    assign m0_bresp   = gnt_q ? 2'b00 : b_resp;
    assign m1_bresp   = gnt_q ? b_resp : 2'b00;
    assign m0_arready = ar_rdy & ~gnt_q;
    assign m1_arready = ar_rdy & gnt_q;
    assign m0_rvalid  = r_vld & ~gnt_q;
    assign m1_rvalid  = r_vld & gnt_q;
    assign m0_rdata   = gnt_q ? 32'h0 : r_data;
    assign m1_rdata   = gnt_q ? r_data : 32'h0;
    assign m0_rresp   = gnt_q ? 2'b00 : r_resp;
    assign m1_rresp   = gnt_q ? r_resp : 2'b00;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXI4L_ARB2_TIMEOUT_EN
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
`endif
        end else begin
`ifdef AXI4L_ARB2_TIMEOUT_EN
            cnt_q <= '0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        gnt_q   <= pick;
                        last_q  <= pick;
                        state_q <= pick_wr ? StGrantWr : StGrantRd;
`ifdef AXI4L_ARB2_TIMEOUT_EN
                        op_wr_q <= pick_wr;
`endif
                    end
                end
                StGrantWr: begin
                    aw_done_q <= aw_done_q | aw_hs;
                    w_done_q  <= w_done_q | w_hs;
                    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_q <= StWaitB;
                end
                StWaitB: begin
                    if (b_hs) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
`ifdef AXI4L_ARB2_TIMEOUT_EN
                        state_q   <= timed_out ? StDrain : StIdle;
                    end else begin
                        cnt_q <= (!s_bvalid && !timed_out) ? cnt_q + 1'b1 : cnt_q;
`else
                        state_q   <= StIdle;
`endif
                    end
                end
                StGrantRd: begin
                    if (ar_hs) state_q <= StWaitR;
                end
                StWaitR: begin
                    if (r_hs) begin
`ifdef AXI4L_ARB2_TIMEOUT_EN
                        state_q <= timed_out ? StDrain : StIdle;
                    end else begin
                        cnt_q <= (!s_rvalid && !timed_out) ? cnt_q + 1'b1 : cnt_q;
`else
                        state_q <= StIdle;
`endif
                    end
                end
`ifdef AXI4L_ARB2_TIMEOUT_EN
                StDrain: begin
                    // Swallow the late slave response so the bank is idle before re-arbitrating.
                    if (op_wr_q ? s_bvalid : s_rvalid) state_q <= StIdle;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_arb2.sv
// Directed self-checking bench for axi4l_arb2; slave responses are driven by hand each step.
module tb_axi4l_arb2;
    localparam int unsigned ADDR_WIDTH = 3;

    logic aclk = 1'b0;
    logic areset;
    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [ADDR_WIDTH-1:2] m0_awaddr, m0_araddr, m1_awaddr, m1_araddr, s_awaddr, s_araddr;
    logic [2:0]  m0_awprot, m0_arprot, m1_awprot, m1_arprot, s_awprot, s_arprot;
    logic [31:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata, s_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [1:0]  m0_bresp, m0_rresp, m1_bresp, m1_rresp, s_bresp, s_rresp;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;

    int total  = 0;
    int passed = 0;

    always #5 aclk = ~aclk;

    axi4l_arb2 #(.ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(8)) dut (
        .aclk(aclk), .areset(areset),
        .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot),
        .m0_awready(m0_awready), .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_wready(m0_wready), .m0_bvalid(m0_bvalid),
        .m0_bresp(m0_bresp), .m0_bready(m0_bready), .m0_arvalid(m0_arvalid),
        .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rready(m0_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot),
        .m1_awready(m1_awready), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
        .m1_bresp(m1_bresp), .m1_bready(m1_bready), .m1_arvalid(m1_arvalid),
        .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rready(m1_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wready(s_wready), .s_bvalid(s_bvalid),
        .s_bresp(s_bresp), .s_bready(s_bready), .s_arvalid(s_arvalid),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rready(s_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; then drive and sample mid-cycle.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        areset = 1'b1;
        {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready} = '0;
        {m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready} = '0;
        {m0_awaddr, m0_araddr, m1_awaddr, m1_araddr} = '0;
        {m0_awprot, m0_arprot, m1_awprot, m1_arprot} = '0;
        {m0_wdata, m1_wdata, m0_wstrb, m1_wstrb} = '0;
        {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = '0;
        {s_bresp, s_rresp, s_rdata} = '0;
        tick();
        tick();
        chk("rst_m0_awready", m0_awready, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_s_wdata", s_wdata, 0);
        areset = 1'b0;

        // 1: m0 write, slave always ready
        m0_awvalid = 1; m0_awaddr = 1'b0; m0_wvalid = 1; m0_wdata = 32'hDEADBEEF;
        m0_wstrb = 4'hF; m0_bready = 1; s_awready = 1; s_wready = 1;
        #1;
        chk("t1_idle_awvalid", s_awvalid, 0);
        tick();
        chk("t1_s_awvalid", s_awvalid, 1);
        chk("t1_s_wvalid", s_wvalid, 1);
        chk("t1_s_wdata", s_wdata, 32'hDEADBEEF);
        chk("t1_m0_awready", m0_awready, 1);
        chk("t1_m1_awready", m1_awready, 0);
        tick();
        m0_awvalid = 0; m0_wvalid = 0; s_bvalid = 1; s_bresp = 2'b00;
        #1;
        chk("t1_s_awvalid_off", s_awvalid, 0);
        chk("t1_m0_bvalid", m0_bvalid, 1);
        chk("t1_m0_bresp", m0_bresp, 0);
        chk("t1_m1_bvalid", m1_bvalid, 0);
        tick();
        s_bvalid = 0;
        #1;
        chk("t1_m0_bvalid_off", m0_bvalid, 0);

        // 2: simultaneous reads straight after reset
        areset = 1; tick(); areset = 0;
        m0_arvalid = 1; m0_araddr = 1'b0; m1_arvalid = 1; m1_araddr = 1'b1;
        m0_rready = 1; m1_rready = 1; s_arready = 1;
        tick();
        chk("t2_s_araddr0", s_araddr, 0);
        chk("t2_m0_arready", m0_arready, 1);
        chk("t2_m1_arready", m1_arready, 0);
        tick();
        m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h11111111;
        #1;
        chk("t2_m0_rvalid", m0_rvalid, 1);
        chk("t2_m0_rdata", m0_rdata, 32'h11111111);
        chk("t2_m1_rvalid", m1_rvalid, 0);
        tick();
        s_rvalid = 0;
        #1;
        chk("t2_idle_arvalid", s_arvalid, 0);
        tick();
        chk("t2_s_araddr1", s_araddr, 1);
        chk("t2_m1_arready", m1_arready, 1);
        tick();
        m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h22222222;
        #1;
        chk("t2_m1_rdata", m1_rdata, 32'h22222222);
        chk("t2_m0_rvalid_off", m0_rvalid, 0);
        tick();
        s_rvalid = 0;

        // 3: m1 W three cycles ahead of AW, awready late
        m1_wvalid = 1; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'h3; m1_bready = 1;
        s_wready = 1; s_awready = 0;
        tick();
        chk("t3_s_wvalid", s_wvalid, 1);
        chk("t3_m1_wready", m1_wready, 1);
        tick();
        m1_wvalid = 0;
        #1;
        chk("t3_s_wvalid_done", s_wvalid, 0);
        tick();
        tick();
        m1_awvalid = 1; m1_awaddr = 1'b1;
        #1;
        chk("t3_s_awaddr", s_awaddr, 1);
        chk("t3_m1_awready_wait", m1_awready, 0);
        tick();
        s_awready = 1;
        #1;
        chk("t3_m1_awready", m1_awready, 1);
        chk("t3_s_wvalid_once", s_wvalid, 0);
        tick();
        m1_awvalid = 0; s_bvalid = 1;
        #1;
        chk("t3_s_awvalid_once", s_awvalid, 0);
        chk("t3_m1_bvalid", m1_bvalid, 1);
        chk("t3_m0_bvalid", m0_bvalid, 0);
        tick();
        s_bvalid = 0;
        #1;
        chk("t3_m1_bvalid_single", m1_bvalid, 0);

        // 4: m0 write+read together; then m1 wins over m0's next read
        m0_awvalid = 1; m0_wvalid = 1; m0_arvalid = 1; m0_araddr = 1'b0;
        tick();
        chk("t4_write_first", s_awvalid, 1);
        chk("t4_no_read_yet", s_arvalid, 0);
        tick();
        m0_awvalid = 0; m0_wvalid = 0; s_bvalid = 1;
        #1;
        chk("t4_m0_bvalid", m0_bvalid, 1);
        tick();
        s_bvalid = 0;
        tick();
        chk("t4_m0_read_next", m0_arready, 1);
        tick();
        m1_arvalid = 1; m1_araddr = 1'b1;
        s_rvalid = 1; s_rdata = 32'h33333333;
        #1;
        chk("t4_m0_rdata", m0_rdata, 32'h33333333);
        tick();
        s_rvalid = 0;
        tick();
        chk("t4_rr_m1_arready", m1_arready, 1);
        chk("t4_rr_m0_arready", m0_arready, 0);
        chk("t4_rr_s_araddr", s_araddr, 1);
        tick();
        m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h44444444;
        #1;
        chk("t4_m1_rdata", m1_rdata, 32'h44444444);
        tick();
        s_rvalid = 0;
        tick();
        chk("t4_m0_pending_served", m0_arready, 1);
        tick();
        m0_arvalid = 0;

        // 5: reset during WAIT_R
        s_rvalid = 1; s_rdata = 32'h99999999;
        areset = 1;
        #1;
        chk("t5_async_m0_rvalid", m0_rvalid, 0);
        chk("t5_async_s_rready", s_rready, 0);
        tick();
        chk("t5_m0_rdata", m0_rdata, 0);
        areset = 0; s_rvalid = 0;
        m1_arvalid = 1; m1_araddr = 1'b0;
        tick();
        chk("t5_m1_arready", m1_arready, 1);
        tick();
        m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h55555555;
        #1;
        chk("t5_m1_rvalid", m1_rvalid, 1);
        chk("t5_m1_rdata", m1_rdata, 32'h55555555);
        tick();
        s_rvalid = 0;

`ifdef AXI4L_ARB2_TIMEOUT_EN
        // 6: slave never answers a read
        m0_arvalid = 1;
        tick();
        tick();
        m0_arvalid = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t6_no_early_rvalid", m0_rvalid, 0);
        end
        tick();
        chk("t6_m0_rvalid", m0_rvalid, 1);
        chk("t6_m0_rresp", m0_rresp, 2'b10);
        chk("t6_m0_rdata", m0_rdata, 0);
        tick();
        chk("t6_drain_rready", s_rready, 1);
        s_rvalid = 1; s_rdata = 32'h77777777;
        #1;
        chk("t6_drain_no_rvalid", m0_rvalid, 0);
        tick();
        s_rvalid = 0;
        #1;
        chk("t6_idle_rready", s_rready, 0);
        chk("t6_idle_no_rvalid", m0_rvalid, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
